// File: rtl/c1541_sd_arb.sv
// c1541_sd_arb
// Round-robin arbiter that places the per-drive SD block requests of the
// multi-drive 1541 complex onto the single host SD channel. One transfer is
// in flight at a time. The host acknowledge is routed back to the granted
// drive, and that drive's write data is muxed onto the host buffer bus.
//
// Parameters:
//   NDR              number of drives served, clamped internally to 1..4
//
// Ports:
//   clk_sys          system clock
//   reset_n          asynchronous active-low reset
//   drv_lba[NDR]     per-drive block address
//   drv_blk_cnt[NDR] per-drive block count minus one
//   drv_rd/drv_wr    per-drive read/write request levels, held until ack
//   drv_buff_din     per-drive write data toward the host
//   drv_ack          per-drive acknowledge (at most one bit high)
//   sd_lba           address latched at grant
//   sd_blk_cnt       block count latched at grant
//   sd_rd/sd_wr      host read/write request
//   sd_ack           host acknowledge, high for the whole transfer
//   sd_buff_din      write data of the granted drive
//   active_drv       index of the granted drive
//   busy             high whenever the arbiter is not idle
//   timeout          sticky REQ timeout flag (only with the macro below)
//
// Optional feature: define C1541_SD_ARB_TIMEOUT_EN to abandon a host request
// that has seen no sd_ack for 2^20-1 cycles and raise the sticky timeout flag.
module c1541_sd_arb #(
    parameter int NDR = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] drv_lba      [NDR],
    input  logic [5:0]  drv_blk_cnt  [NDR],
    input  logic [NDR-1:0] drv_rd,
    input  logic [NDR-1:0] drv_wr,
    input  logic [7:0]  drv_buff_din [NDR],
    output logic [NDR-1:0] drv_ack,
    output logic [31:0] sd_lba,
    output logic [5:0]  sd_blk_cnt,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [7:0]  sd_buff_din,
    output logic [1:0]  active_drv,
    output logic        busy
`ifdef C1541_SD_ARB_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam int N = (NDR < 1) ? 1 : ((NDR > 4) ? 4 : NDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  last;

    // Inputs padded to four slots so that every index below is a plain
    // 2-bit select; slots beyond the served drive count read as idle.
    logic [3:0]  rd_v;
    logic [3:0]  wr_v;
    logic [31:0] lba_v [4];
    logic [5:0]  cnt_v [4];
    logic [7:0]  din_v [4];

    for (genvar g = 0; g < 4; g++) begin : g_pad
        if (g < N) begin : g_used
            assign rd_v[g]  = drv_rd[g];
            assign wr_v[g]  = drv_wr[g];
            assign lba_v[g] = drv_lba[g];
            assign cnt_v[g] = drv_blk_cnt[g];
            assign din_v[g] = drv_buff_din[g];
        end else begin : g_unused
            assign rd_v[g]  = 1'b0;
            assign wr_v[g]  = 1'b0;
            assign lba_v[g] = '0;
            assign cnt_v[g] = '0;
            assign din_v[g] = '0;
        end
    end

    for (genvar g = 0; g < NDR; g++) begin : g_ack
        if (g < N) begin : g_live
            assign drv_ack[g] = sd_ack & busy & (active_drv == 2'(g));
        end else begin : g_dead
            assign drv_ack[g] = 1'b0;
        end
    end

    assign sd_buff_din = din_v[active_drv];

    // Round-robin scan: start one past the last granted drive and take the
    // first one with any request pending. Read wins when both are raised.
    logic       found;
    logic       pick_rd;
    logic [1:0] pick;
    logic [2:0] cand;

    always_comb begin
        found   = 1'b0;
        pick    = last;
        pick_rd = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = 3'(int'(last) + k);
            if (cand >= 3'(N)) begin
                cand = cand - 3'(N);
            end
            if (!found && (rd_v[cand[1:0]] | wr_v[cand[1:0]])) begin
                found   = 1'b1;
                pick    = cand[1:0];
                pick_rd = rd_v[cand[1:0]];
            end
        end
    end

    // The granted drive withdrawing both requests before the host answers
    // means it was reset; the request is abandoned.
    logic act_req;
    assign act_req = rd_v[active_drv] | wr_v[active_drv];

`ifdef C1541_SD_ARB_TIMEOUT_EN
    logic [19:0] to_cnt;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= 2'(N - 1);
            active_drv <= '0;
            sd_lba     <= '0;
            sd_blk_cnt <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            busy       <= 1'b0;
`ifdef C1541_SD_ARB_TIMEOUT_EN
            to_cnt     <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sd_lba     <= lba_v[pick];
                        sd_blk_cnt <= cnt_v[pick];
                        active_drv <= pick;
                        last       <= pick;
                        sd_rd      <= pick_rd;
                        sd_wr      <= !pick_rd;
                        busy       <= 1'b1;
                        state      <= REQ;
`ifdef C1541_SD_ARB_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
`ifdef C1541_SD_ARB_TIMEOUT_EN
                        timeout <= 1'b0;
`endif
                    end else if (!act_req) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`ifdef C1541_SD_ARB_TIMEOUT_EN
                    else if (to_cnt == '1) begin
                        // Host never answered: give up, keep the guard cycle
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 20'd1;
                    end
`endif
                end
                XFER: begin
                    if (!sd_ack) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Guard cycle so the served drive can drop its request
                    // before the next scan.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1541_sd_arb.sv
// Testbench for c1541_sd_arb: a two-drive instance driven from a vector
// table plus hand-written reset sequences, and a four-drive instance driven
// with random requests and a reactive host, checked against a transaction
// level reference model.
module tb_c1541_sd_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Two-drive instance
    logic [31:0] a_lba [2];
    logic [5:0]  a_cnt [2];
    logic [1:0]  a_rd, a_wr;
    logic [7:0]  a_din [2];
    logic [1:0]  a_dack;
    logic [31:0] a_sd_lba;
    logic [5:0]  a_sd_cnt;
    logic        a_sd_rd, a_sd_wr, a_ack;
    logic [7:0]  a_sd_din;
    logic [1:0]  a_act;
    logic        a_busy;

    // Four-drive instance
    logic [31:0] b_lba [4];
    logic [5:0]  b_cnt [4];
    logic [3:0]  b_rd, b_wr;
    logic [7:0]  b_din [4];
    logic [3:0]  b_dack;
    logic [31:0] b_sd_lba;
    logic [5:0]  b_sd_cnt;
    logic        b_sd_rd, b_sd_wr, b_ack;
    logic [7:0]  b_sd_din;
    logic [1:0]  b_act;
    logic        b_busy;

    c1541_sd_arb #(.NDR(2)) u2 (
        .clk_sys(clk), .reset_n(rst_n),
        .drv_lba(a_lba), .drv_blk_cnt(a_cnt),
        .drv_rd(a_rd), .drv_wr(a_wr), .drv_buff_din(a_din),
        .drv_ack(a_dack), .sd_lba(a_sd_lba), .sd_blk_cnt(a_sd_cnt),
        .sd_rd(a_sd_rd), .sd_wr(a_sd_wr), .sd_ack(a_ack),
        .sd_buff_din(a_sd_din), .active_drv(a_act), .busy(a_busy)
    );

    c1541_sd_arb #(.NDR(4)) u4 (
        .clk_sys(clk), .reset_n(rst_n),
        .drv_lba(b_lba), .drv_blk_cnt(b_cnt),
        .drv_rd(b_rd), .drv_wr(b_wr), .drv_buff_din(b_din),
        .drv_ack(b_dack), .sd_lba(b_sd_lba), .sd_blk_cnt(b_sd_cnt),
        .sd_rd(b_sd_rd), .sd_wr(b_sd_wr), .sd_ack(b_ack),
        .sd_buff_din(b_sd_din), .active_drv(b_act), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        ack;
        logic        e_rd;
        logic        e_wr;
        logic        e_busy;
        logic [1:0]  e_act;
        logic [1:0]  e_dack;
        logic [31:0] e_lba;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic ack,
                       input logic e_rd, input logic e_wr, input logic e_busy,
                       input logic [1:0] e_act, input logic [1:0] e_dack,
                       input logic [31:0] e_lba, input logic [5:0] e_cnt);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ack = ack;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_busy = e_busy;
        v.e_act = e_act; v.e_dack = e_dack; v.e_lba = e_lba; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_sd_rd"}, 64'(a_sd_rd), 64'd0);
        chk({tag, "_sd_wr"}, 64'(a_sd_wr), 64'd0);
        chk({tag, "_busy"},  64'(a_busy), 64'd0);
        chk({tag, "_act"},   64'(a_act), 64'd0);
        chk({tag, "_dack"},  64'(a_dack), 64'd0);
        chk({tag, "_lba"},   64'(a_sd_lba), 64'd0);
        chk({tag, "_cnt"},   64'(a_sd_cnt), 64'd0);
    endtask

    // Reference model state for the four-drive instance
    bit          m_free = 1'b1;
    bit          m_dir_rd = 1'b0;
    int          m_last = 3;
    int          m_g = 0;
    int          m_phase = 0;   // 0 waiting for host ack, 1 transfer, 2 guard
    logic [31:0] m_lba = '0;
    logic [5:0]  m_cnt = '0;
    int          grants = 0;
    int          h_wait = -1;
    int          h_len = 0;

    initial begin
        rst_n = 1'b0;
        a_rd = '0; a_wr = '0; a_ack = 1'b0;
        a_lba[0] = 32'h0000_0123; a_cnt[0] = 6'd0; a_din[0] = 8'h3C;
        a_lba[1] = 32'h0000_0456; a_cnt[1] = 6'd5; a_din[1] = 8'hA5;
        b_rd = '0; b_wr = '0; b_ack = 1'b0;
        for (int d = 0; d < 4; d++) begin
            b_lba[d] = '0; b_cnt[d] = '0; b_din[d] = '0;
        end

        //    rd     wr     ack   e_rd e_wr busy act  dack   lba            cnt
        add(2'b01, 2'b00, 1'b0, 1, 0, 1, 2'd0, 2'b00, 32'h123, 6'd0); // single read granted
        add(2'b01, 2'b00, 1'b0, 1, 0, 1, 2'd0, 2'b00, 32'h123, 6'd0);
        add(2'b01, 2'b00, 1'b1, 0, 0, 1, 2'd0, 2'b01, 32'h123, 6'd0);
        add(2'b01, 2'b00, 1'b1, 0, 0, 1, 2'd0, 2'b01, 32'h123, 6'd0);
        add(2'b00, 2'b00, 1'b0, 0, 0, 1, 2'd0, 2'b00, 32'h123, 6'd0); // guard
        add(2'b00, 2'b00, 1'b0, 0, 0, 0, 2'd0, 2'b00, 32'h123, 6'd0); // idle
        add(2'b00, 2'b10, 1'b0, 0, 1, 1, 2'd1, 2'b00, 32'h456, 6'd5); // write drive 1
        add(2'b00, 2'b10, 1'b1, 0, 0, 1, 2'd1, 2'b10, 32'h456, 6'd5);
        add(2'b00, 2'b00, 1'b0, 0, 0, 1, 2'd1, 2'b00, 32'h456, 6'd5);
        add(2'b00, 2'b00, 1'b0, 0, 0, 0, 2'd1, 2'b00, 32'h456, 6'd5);
        add(2'b01, 2'b01, 1'b0, 1, 0, 1, 2'd0, 2'b00, 32'h123, 6'd0); // rd+wr: read wins
        add(2'b00, 2'b00, 1'b0, 0, 0, 0, 2'd0, 2'b00, 32'h123, 6'd0); // abort
        add(2'b00, 2'b00, 1'b1, 0, 0, 0, 2'd0, 2'b00, 32'h123, 6'd0); // stray ack
        add(2'b00, 2'b00, 1'b0, 0, 0, 0, 2'd0, 2'b00, 32'h123, 6'd0);
        add(2'b11, 2'b00, 1'b0, 1, 0, 1, 2'd1, 2'b00, 32'h456, 6'd5); // contention
        add(2'b11, 2'b00, 1'b1, 0, 0, 1, 2'd1, 2'b10, 32'h456, 6'd5);
        add(2'b01, 2'b00, 1'b0, 0, 0, 1, 2'd1, 2'b00, 32'h456, 6'd5);
        add(2'b11, 2'b00, 1'b0, 0, 0, 0, 2'd1, 2'b00, 32'h456, 6'd5);
        add(2'b11, 2'b00, 1'b0, 1, 0, 1, 2'd0, 2'b00, 32'h123, 6'd0);
        add(2'b11, 2'b00, 1'b1, 0, 0, 1, 2'd0, 2'b01, 32'h123, 6'd0);
        add(2'b10, 2'b00, 1'b0, 0, 0, 1, 2'd0, 2'b00, 32'h123, 6'd0);
        add(2'b11, 2'b00, 1'b0, 0, 0, 0, 2'd0, 2'b00, 32'h123, 6'd0);
        add(2'b11, 2'b00, 1'b0, 1, 0, 1, 2'd1, 2'b00, 32'h456, 6'd5);

        // Reset state
        #1;
        check_a_zero("reset");
        chk("reset_b_busy", 64'(b_busy), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Vector table on the two-drive instance
        foreach (tbl[i]) begin
            a_rd = tbl[i].rd; a_wr = tbl[i].wr; a_ack = tbl[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_sd_rd", i), 64'(a_sd_rd), 64'(tbl[i].e_rd));
            chk($sformatf("v%0d_sd_wr", i), 64'(a_sd_wr), 64'(tbl[i].e_wr));
            chk($sformatf("v%0d_busy", i),  64'(a_busy), 64'(tbl[i].e_busy));
            chk($sformatf("v%0d_act", i),   64'(a_act), 64'(tbl[i].e_act));
            chk($sformatf("v%0d_dack", i),  64'(a_dack), 64'(tbl[i].e_dack));
            chk($sformatf("v%0d_lba", i),   64'(a_sd_lba), 64'(tbl[i].e_lba));
            chk($sformatf("v%0d_cnt", i),   64'(a_sd_cnt), 64'(tbl[i].e_cnt));
            chk($sformatf("v%0d_buff", i),  64'(a_sd_din),
                (tbl[i].e_act == 2'd1) ? 64'h A5 : 64'h3C);
        end

        // Async reset in the middle of a transfer (drive 1 was just granted)
        a_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("xfer_dack", 64'(a_dack), 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check_a_zero("async");
        a_rd = 2'b10; a_ack = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_sd_rd", 64'(a_sd_rd), 64'd1);
        chk("post_rst_act", 64'(a_act), 64'd1);
        chk("post_rst_lba", 64'(a_sd_lba), 64'h456);
        a_rd = 2'b00;

        // Random traffic on the four-drive instance
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] req;
            logic [3:0] e_dack;
            for (int d = 0; d < 4; d++) begin
                b_lba[d] = $urandom;
                b_cnt[d] = 6'($urandom);
                b_din[d] = 8'($urandom);
            end
            req = b_rd | b_wr;

            // Model the outcome of this clock edge from the applied inputs
            if (m_free) begin
                if (req != 4'b0) begin
                    for (int k = 1; k <= 4; k++) begin
                        int idx;
                        idx = (m_last + k) % 4;
                        if (m_free && req[idx]) begin
                            m_g = idx;
                            m_free = 1'b0;
                        end
                    end
                    m_last = m_g;
                    m_dir_rd = b_rd[m_g];
                    m_lba = b_lba[m_g];
                    m_cnt = b_cnt[m_g];
                    m_phase = 0;
                    grants++;
                end
            end else if (m_phase == 0) begin
                if (b_ack) m_phase = 1;
            end else if (m_phase == 1) begin
                if (!b_ack) m_phase = 2;
            end else begin
                m_free = 1'b1;
            end

            @(posedge clk);
            #1;
            e_dack = (b_ack && !m_free) ? 4'(1 << m_g) : 4'b0;
            chk("r_busy", 64'(b_busy), 64'(!m_free));
            chk("r_sd_rd", 64'(b_sd_rd), 64'(!m_free && m_phase == 0 && m_dir_rd));
            chk("r_sd_wr", 64'(b_sd_wr), 64'(!m_free && m_phase == 0 && !m_dir_rd));
            chk("r_act", 64'(b_act), 64'(m_g));
            chk("r_lba", 64'(b_sd_lba), 64'(m_lba));
            chk("r_cnt", 64'(b_sd_cnt), 64'(m_cnt));
            chk("r_dack", 64'(b_dack), 64'(e_dack));
            chk("r_buff", 64'(b_sd_din), 64'(b_din[m_g]));

            // Drives: drop on ack, otherwise occasionally raise a new request
            for (int d = 0; d < 4; d++) begin
                if (b_dack[d]) begin
                    b_rd[d] = 1'b0;
                    b_wr[d] = 1'b0;
                end else if (!(b_rd[d] | b_wr[d]) && ($urandom % 3 == 0)) begin
                    case ($urandom % 3)
                        0: b_rd[d] = 1'b1;
                        1: b_wr[d] = 1'b1;
                        default: begin b_rd[d] = 1'b1; b_wr[d] = 1'b1; end
                    endcase
                end
            end

            // Host: answer a request after a short delay, ack for a few cycles
            if (b_ack) begin
                h_len--;
                if (h_len <= 0) b_ack = 1'b0;
            end else if (h_wait > 0) begin
                h_wait--;
            end else if (h_wait == 0) begin
                b_ack = 1'b1;
                h_wait = -1;
            end else if (b_sd_rd | b_sd_wr) begin
                h_wait = int'($urandom_range(0, 2));
                h_len = int'($urandom_range(1, 4));
                if (h_wait == 0) begin
                    b_ack = 1'b1;
                    h_wait = -1;
                end
            end
        end
        chk("r_progress", 64'(grants >= 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c1541_sd_arb.md
Name: c1541_sd_arb

Overview:
- Arbitrates the per-drive SD block requests of the multi-drive 1541 complex (sd_rd/sd_wr/sd_lba/sd_blk_cnt vectors, one entry per drive) onto the single host SD channel.
- Routes the host acknowledge back to the granted drive.
- Muxes the granted drive's write data onto the host buffer bus.
- Sits directly downstream of c1541_multi in the clk_sys domain; round-robin fairness, one transfer in flight at a time.

Parameters:
- NDR, 2, number of drives served (1..4); values outside this range are clamped.

Ports:
- clk_sys  in  1  system clock; all logic synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- drv_lba[NDR]  in  32  per-drive block address.
- drv_blk_cnt[NDR]  in  6  per-drive block count minus one.
- drv_rd  in  NDR  per-drive read request, level, held until its ack.
- drv_wr  in  NDR  per-drive write request, level, held until its ack.
- drv_buff_din[NDR]  in  8  per-drive write data toward host.
- drv_ack  out  NDR  per-drive acknowledge.
- sd_lba  out  32  latched address of the granted request.
- sd_blk_cnt  out  6  latched block count of the granted request.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host acknowledge; high for the whole transfer.
- sd_buff_din  out  8  write data from the granted drive.
- active_drv  out  2  index of the granted drive.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, active_drv=0, busy=0, drv_ack=0.
  - State=IDLE; round-robin pointer last=NDR-1, so drive 0 is first in priority.
  - Deassertion takes effect on the next clk_sys edge.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - Scan drives starting at last+1 mod NDR.
  - The first drive i with drv_rd[i]|drv_wr[i] is granted.
  - On grant: latch sd_lba=drv_lba[i], sd_blk_cnt=drv_blk_cnt[i], active_drv=i, last=i.
  - Direction: read if drv_rd[i], otherwise write; if both are high, read wins.
  - Next cycle: sd_rd or sd_wr=1, busy=1, state=REQ. Latency from request to host request is one clk_sys cycle.
- REQ:
  - Hold sd_rd/sd_wr until sd_ack=1, then clear both and go to XFER in the same edge.
  - If the granted drive drops both its requests before ack (drive reset), clear sd_rd/sd_wr and return to IDLE; no ack is forwarded.
- XFER: stay until sd_ack=0, then go to DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE with busy=0.
  - This guard cycle lets the granted drive withdraw its request before rescanning.
- drv_ack:
  - Combinational: drv_ack[i] = sd_ack & busy & (active_drv==i).
  - Never more than one bit high.
  - An sd_ack arriving in IDLE is ignored (no drv_ack).
- sd_buff_din:
  - Combinational: drv_buff_din[active_drv].
  - Value is don't-care when busy=0, but driven from drive active_drv, never X.
- Latched fields do not change while busy, even if drive inputs change.
- Simultaneous requests: served one per arbitration in rotating order.
  - With NDR=4 and all drives requesting continuously, the grant order is 0,1,2,3,0,…
- NDR=1: active_drv is always 0 and rotation is trivial.
- sd_rd and sd_wr are never high together.

Optional Feature:
- Macro: C1541_SD_ARB_TIMEOUT_EN.
- When defined:
  - A 20-bit counter is cleared on entry to REQ and increments each REQ cycle.
  - At 2^20-1 cycles without sd_ack, sd_rd/sd_wr are cleared and the state goes to DONE.
  - A sticky output timeout (1 bit, reset 0) is set; it is cleared on the next successful ack.
  - Rotation advances as normal.
- When undefined: no counter, no timeout port, and REQ waits indefinitely.

Test Plan:
- Single read: NDR=2, reset, drv_rd=2'b01, drv_lba[0]=32'h00000123, drv_blk_cnt[0]=0.
  - Expect sd_rd=1 one cycle later and sd_lba=32'h123.
  - Raise sd_ack for 10 cycles: drv_ack=2'b01 during ack, sd_rd=0 after the first ack edge, busy=0 two cycles after ack falls.
- Contention: drv_rd=2'b11 held; each drive drops its request on its ack.
  - Grants go drive 0 then drive 1.
  - Repeating with both requests re-asserted gives drive 1 skipped (already served) in favour of drive 0 per the last pointer; the order must alternate.
- Write path: drv_wr[1]=1, drv_buff_din[1]=8'hA5, drv_buff_din[0]=8'h3C.
  - During ack: sd_wr was 1 before ack, sd_buff_din=8'hA5, drv_ack=2'b10.
- Read/write collision: drv_rd[0]=drv_wr[0]=1 gives sd_rd=1, sd_wr=0.
- Abort: in REQ, drop drv_rd[0] before any ack.
  - sd_rd=0 next cycle, state IDLE, no drv_ack pulse.
  - A later stray sd_ack produces no drv_ack.
- Async reset mid-XFER: pull reset_n low while sd_ack=1.
  - All outputs go to 0 immediately without a clock.
  - After release with drv_rd=2'b10, drive 1 is granted.
